draw_image: RTL and testbench
=============================

# draw_image

Pipelined overlay stage that draws a 48 x 64 sprite onto the VGA pixel stream. It sits directly upstream of `image_rom`: it turns the current pixel counters and a sprite position into the ROM address `{y[5:0], x[5:0]}`. When the ROM pixel returns one cycle later, it muxes that pixel over the background `rgb`. It also delays every timing signal so that sync, blanking and colour stay aligned at the output.

## Interface
Parameters:
- `IMG_W`, 48, sprite width in pixels (1..64)
- `IMG_H`, 64, sprite height in pixels (1..64)
- `KEY_RGB`, 12'h0F0, transparent colour; ROM pixels equal to it show the background

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  pixel clock
- `rst`  in  1  synchronous active-high reset
- `xpos`  in  12  requested sprite left edge, in pixels
- `ypos`  in  12  requested sprite top edge, in lines
- `enable`  in  1  sprite visible; sampled together with `xpos`/`ypos`
- `hcount_in`, `vcount_in`  in  11 each  pixel counters
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in`  in  1 each  timing from upstream
- `rgb_in`  in  12  background colour
- `rom_addr`  out  12  to `image_rom.address`, as `{dy[5:0], dx[5:0]}`
- `rom_rgb`  in  12  from `image_rom.rgb` (1-cycle ROM latency)
- `hcount_out`, `vcount_out`  out  11 each  counters delayed by 3 cycles
- `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out`  out  1 each  timing delayed by 3 cycles
- `rgb_out`  out  12  composited colour

## Operation
- **Position latch.**
  - `xpos`, `ypos` and `enable` are captured into `x_lat`, `y_lat` and `en_lat` only on the cycle where `hcount_in==0 && vcount_in==0`. This is the frame start.
  - Mid-frame changes therefore never tear the sprite.
  - Reset clears `x_lat`, `y_lat` and `en_lat` to 0.
- **Stage 1** (registered on the cycle after the input):
  - `dx = hcount_in - x_lat` and `dy = vcount_in - y_lat`, computed as 12-bit unsigned.
  - `inside = en_lat && hcount_in >= x_lat && hcount_in < x_lat + IMG_W && vcount_in >= y_lat && vcount_in < y_lat + IMG_H`.
  - Comparisons are 13-bit wide so that `x_lat + IMG_W` cannot wrap.
  - `rom_addr <= inside ? {dy[5:0], dx[5:0]} : 12'h000`.
  - `inside`, the timing signals, the counters and `rgb_in` are delayed one stage.
- **Stage 2:** ROM output becomes valid. The `inside` flag, timing, counters and `rgb` are delayed one more stage.
- **Stage 3** (output register):
  - If `hblnk` or `vblnk` (delayed) is set, `rgb_out = 12'h000`.
  - Else if `inside` and `rom_rgb != KEY_RGB`, `rgb_out = rom_rgb`.
  - Else `rgb_out = rgb` (delayed background).
- **Clipping.**
  - A sprite partly beyond the visible area is clipped naturally, because the counters never reach off-screen coordinates.
  - `x_lat >= 4096 - IMG_W` is legal; the comparison is non-wrapping, so the sprite is simply not drawn.
- **No state machine beyond the pipeline.** All delay registers are plain shift stages of equal depth.

## Timing
- Latency from input to every `*_out` is exactly 3 `clk` cycles, for all signals alike.
- `rom_addr` lags the inputs by exactly 1 cycle. The ROM result is consumed 1 cycle after `rom_addr`.
- Throughput is one pixel per cycle, with no stalls and no handshake.
- **Reset** (synchronous):
  - On the cycle after `rst` is sampled high, all outputs are 0: `rom_addr=0`, `rgb_out=0`, syncs 0, blanks 0, counters 0.
  - The pipeline is flushed. Valid outputs resume 3 cycles after `rst` deasserts.
  - `en_lat` stays 0, so no sprite is drawn until the next frame start.
- **Reset mid-frame:** same as above. No stale sprite pixels appear after reset.
- **Simultaneous events:**
  - A position change on the frame-start cycle is captured and applies to that same frame, including pixel (0,0).
  - A change on any other cycle is ignored until the next frame start.

## Test plan
- **Basic draw.** Reset, then frame start with `xpos=100`, `ypos=50`, `enable=1`, and ROM modelled as `rom[a]=a`. At input (`hcount=100`, `vcount=50`): `rom_addr=12'h000` one cycle later and `rgb_out=12'h000` three cycles later. At (`hcount=147`, `vcount=113`): `rom_addr=12'hFEF` (`dy=63`, `dx=47`) one cycle later and `rgb_out=12'hFEF` three cycles later.
- **Edges and background.** With `rgb_in=12'h00F`, the pixels at `hcount=99`, `hcount=148` and `vcount=114` give `rgb_out=12'h00F` and `rom_addr=0`.
- **Transparency and blanking.**
  - A ROM word equal to `12'h0F0` inside the sprite gives `rgb_out=rgb_in`.
  - `hblnk_in=1` inside the sprite region gives `rgb_out=0` with `hblnk_out=1` three cycles later.
- **Tear-free latch.** Change `xpos` 100→300 mid-frame. The rest of the frame still draws at x=100; the next frame draws at x=300.
- **Clipping.** `xpos=780`, `ypos=580` on 800x600 timing: only the 20x20 visible corner is drawn, with `rom_addr` `dx` 0..19. `xpos=4090`: nothing is drawn and no wrap-around pixels appear at x=0..41.
- **Reset mid-frame.** Assert `rst` for 1 cycle while inside the sprite. All outputs are 0 the following cycle; after deassert, `*_out` track the inputs with 3-cycle delay and no sprite appears until the next frame start.

Source files
------------

// File: rtl/draw_image.sv
// draw_image
//   Three-stage overlay pipeline that draws an IMG_W x IMG_H sprite onto a
//   VGA pixel stream. Stage 1 turns the pixel counters and the latched sprite
//   position into a ROM address. Stage 2 waits for the single-cycle ROM.
//   Stage 3 composites the ROM pixel over the background. Timing signals and
//   counters travel alongside the pixel, so everything at the output stays
//   aligned.
//
// Ports
//   clk                      pixel clock
//   rst                      synchronous active-high reset
//   xpos, ypos, enable       requested sprite position and visibility,
//                            latched only at frame start (0,0)
//   hcount_in, vcount_in     pixel counters
//   hsync_in, vsync_in       sync from upstream
//   hblnk_in, vblnk_in       blanking from upstream
//   rgb_in                   background colour
//   rom_addr                 {dy[5:0], dx[5:0]} to image_rom, 1 cycle after input
//   rom_rgb                  image_rom data, valid 1 cycle after rom_addr
//   *_out                    counters, timing and colour, 3 cycles after input
module draw_image #(
  parameter int          IMG_W   = 48,
  parameter int          IMG_H   = 64,
  parameter logic [11:0] KEY_RGB = 12'h0F0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        enable,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_rgb,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  // Sideband bundle carried through stages 1 and 2:
  // {inside, hcount, vcount, hsync, vsync, hblnk, vblnk, rgb}
  localparam int PW = 1 + 11 + 11 + 4 + 12;

  logic [11:0] x_lat_reg, y_lat_reg;
  logic        en_lat_reg;

  logic        frame_start;
  logic [11:0] x_eff, y_eff;
  logic        en_eff;
  logic [12:0] h13, v13, x13, y13, xend13, yend13;
  logic [5:0]  dx6, dy6;
  logic        inside_next;
  logic [11:0] rom_addr_reg;

  logic [PW-1:0] pipe_reg [0:1];
  logic [PW-1:0] stage_in;

  logic        inside2;
  logic [10:0] hcount2, vcount2;
  logic        hsync2, vsync2, hblnk2, vblnk2;
  logic [11:0] rgb2;
  logic [11:0] rgb_next;

  logic [10:0] hcount_reg, vcount_reg;
  logic        hsync_reg, vsync_reg, hblnk_reg, vblnk_reg;
  logic [11:0] rgb_reg;

  // On the frame-start pixel the new position is used straight away, so the
  // update applies to pixel (0,0) of the same frame.
  assign frame_start = (hcount_in == 11'd0) && (vcount_in == 11'd0);
  assign x_eff       = frame_start ? xpos   : x_lat_reg;
  assign y_eff       = frame_start ? ypos   : y_lat_reg;
  assign en_eff      = frame_start ? enable : en_lat_reg;

  // 13-bit compares: x + IMG_W must not wrap for positions near 4095.
  assign h13    = {2'b00, hcount_in};
  assign v13    = {2'b00, vcount_in};
  assign x13    = {1'b0, x_eff};
  assign y13    = {1'b0, y_eff};
  assign xend13 = x13 + 13'(IMG_W);
  assign yend13 = y13 + 13'(IMG_H);

  assign inside_next = en_eff && (h13 >= x13) && (h13 < xend13)
                              && (v13 >= y13) && (v13 < yend13);

  // Only the low six bits of the offsets form the address.
  assign dx6 = hcount_in[5:0] - x_eff[5:0];
  assign dy6 = vcount_in[5:0] - y_eff[5:0];

  assign stage_in = {inside_next, hcount_in, vcount_in,
                     hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      x_lat_reg  <= 12'd0;
      y_lat_reg  <= 12'd0;
      en_lat_reg <= 1'b0;
    end else if (frame_start) begin
      x_lat_reg  <= xpos;
      y_lat_reg  <= ypos;
      en_lat_reg <= enable;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_reg <= 12'd0;
    end else begin
      rom_addr_reg <= inside_next ? {dy6, dx6} : 12'h000;
    end
  end

  // Stages 1 and 2: plain shift registers of the sideband bundle.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_pipe
      always_ff @(posedge clk) begin
        if (rst) begin
          pipe_reg[gi] <= '0;
        end else if (gi == 0) begin
          pipe_reg[gi] <= stage_in;
        end else begin
          pipe_reg[gi] <= pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  assign {inside2, hcount2, vcount2, hsync2, vsync2, hblnk2, vblnk2, rgb2} = pipe_reg[1];

  // rom_rgb now belongs to the pixel held in stage 2.
  always_comb begin
    rgb_next = rgb2;
    if (hblnk2 || vblnk2) begin
      rgb_next = 12'h000;
    end else if (inside2 && (rom_rgb != KEY_RGB)) begin
      rgb_next = rom_rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_reg <= 11'd0;
      vcount_reg <= 11'd0;
      hsync_reg  <= 1'b0;
      vsync_reg  <= 1'b0;
      hblnk_reg  <= 1'b0;
      vblnk_reg  <= 1'b0;
      rgb_reg    <= 12'd0;
    end else begin
      hcount_reg <= hcount2;
      vcount_reg <= vcount2;
      hsync_reg  <= hsync2;
      vsync_reg  <= vsync2;
      hblnk_reg  <= hblnk2;
      vblnk_reg  <= vblnk2;
      rgb_reg    <= rgb_next;
    end
  end

  assign rom_addr   = rom_addr_reg;
  assign hcount_out = hcount_reg;
  assign vcount_out = vcount_reg;
  assign hsync_out  = hsync_reg;
  assign vsync_out  = vsync_reg;
  assign hblnk_out  = hblnk_reg;
  assign vblnk_out  = vblnk_reg;
  assign rgb_out    = rgb_reg;

endmodule

// File: tb/tb_draw_image.sv
module tb_draw_image;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] xpos, ypos;
  logic        enable;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [11:0] rom_addr;
  logic [11:0] rom_rgb;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  draw_image dut (
    .clk(clk), .rst(rst),
    .xpos(xpos), .ypos(ypos), .enable(enable),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .rom_addr(rom_addr), .rom_rgb(rom_rgb),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  // ROM: rom[a] = a, except one word holding the transparent key colour.
  always_ff @(posedge clk) begin
    rom_rgb <= (rom_addr == 12'h0C5) ? 12'h0F0 : rom_addr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Apply one pixel, hold it, check rom_addr after 1 cycle and rgb_out after 3.
  task automatic px(input string tag, input int h, input int v,
                    input logic [11:0] exp_addr, input logic [11:0] exp_rgb);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    tick();
    chk({tag, "_addr"}, rom_addr, exp_addr);
    tick();
    tick();
    chk({tag, "_rgb"}, rgb_out, exp_rgb);
    $display("[TB] px %s (%0d,%0d) addr=%h rgb=%h", tag, h, v, rom_addr, rgb_out);
  endtask

  task automatic frame_start(input int x, input int y, input logic en);
    hcount_in = 11'd0;
    vcount_in = 11'd0;
    xpos = 12'(x);
    ypos = 12'(y);
    enable = en;
    tick();
    $display("[TB] frame start x=%0d y=%0d en=%0d", x, y, en);
  endtask

  initial begin
    rst = 1'b1;
    xpos = 12'd0; ypos = 12'd0; enable = 1'b0;
    hcount_in = 11'd5; vcount_in = 11'd5;
    hsync_in = 1'b1; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    rgb_in = 12'hFFF;
    tick();
    tick();
    chk("rst_addr",   rom_addr, 12'h000);
    chk("rst_rgb",    rgb_out, 12'h000);
    chk("rst_hsync",  {11'd0, hsync_out}, 12'h000);
    chk("rst_hcount", {1'b0, hcount_out}, 12'h000);
    rst = 1'b0;
    hsync_in = 1'b0;
    rgb_in = 12'h00F;

    // Latency: a one-cycle vsync pulse with counter 7 appears exactly 3 cycles later.
    hcount_in = 11'd7; vcount_in = 11'd3; vsync_in = 1'b1;
    tick();
    hcount_in = 11'd8; vsync_in = 1'b0;
    tick();
    chk("lat_vs_c2", {11'd0, vsync_out}, 12'h000);
    tick();
    chk("lat_vs_c3", {11'd0, vsync_out}, 12'h001);
    chk("lat_hc_c3", {1'b0, hcount_out}, 12'd7);
    chk("lat_vc_c3", {1'b0, vcount_out}, 12'd3);
    tick();
    chk("lat_vs_c4", {11'd0, vsync_out}, 12'h000);
    chk("lat_hc_c4", {1'b0, hcount_out}, 12'd8);

    // Same-frame capture at pixel (0,0).
    xpos = 12'd0; ypos = 12'd0; enable = 1'b1;
    px("origin", 0, 0, 12'h000, 12'h000);
    px("one_one", 1, 1, 12'h041, 12'h041);

    // Basic draw and edges.
    frame_start(100, 50, 1'b1);
    px("tl",       100,  50, 12'h000, 12'h000);
    px("br",       147, 113, 12'hFEF, 12'hFEF);
    px("left_out",  99,  50, 12'h000, 12'h00F);
    px("right_out",148,  50, 12'h000, 12'h00F);
    px("bot_out",  100, 114, 12'h000, 12'h00F);

    // Transparency and blanking.
    px("key", 105, 53, 12'h0C5, 12'h00F);
    hblnk_in = 1'b1;
    px("hblnk", 110, 60, 12'h28A, 12'h000);
    chk("hblnk_out", {11'd0, hblnk_out}, 12'h001);
    hblnk_in = 1'b0;

    // Tear-free latch: mid-frame xpos change is ignored until next frame.
    xpos = 12'd300;
    px("tear_old", 110, 51, 12'h04A, 12'h04A);
    px("tear_new", 310, 51, 12'h000, 12'h00F);
    frame_start(300, 50, 1'b1);
    px("next_old", 110, 51, 12'h000, 12'h00F);
    px("next_new", 310, 51, 12'h04A, 12'h04A);

    // Clipping near the bottom-right of 800x600.
    frame_start(780, 580, 1'b1);
    px("clip_tl",  780, 580, 12'h000, 12'h000);
    px("clip_br",  799, 599, 12'h4D3, 12'h4D3);
    px("clip_out", 779, 580, 12'h000, 12'h00F);

    // Position near 4095: no wrap-around pixels at the left edge.
    frame_start(4090, 0, 1'b1);
    px("wrap_x5",   5, 0, 12'h000, 12'h00F);
    px("wrap_x41", 41, 10, 12'h000, 12'h00F);

    // Reset mid-frame while inside the sprite.
    frame_start(100, 50, 1'b1);
    hcount_in = 11'd110; vcount_in = 11'd51; hsync_in = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_addr",   rom_addr, 12'h000);
    chk("mrst_rgb",    rgb_out, 12'h000);
    chk("mrst_hsync",  {11'd0, hsync_out}, 12'h000);
    chk("mrst_hcount", {1'b0, hcount_out}, 12'h000);
    chk("mrst_vcount", {1'b0, vcount_out}, 12'h000);
    rst = 1'b0;
    px("post_rst", 110, 51, 12'h000, 12'h00F);
    chk("post_hsync",  {11'd0, hsync_out}, 12'h001);
    chk("post_hcount", {1'b0, hcount_out}, 12'd110);
    hsync_in = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
